// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the host command sequencer:
//   - command opcodes carried in the first byte of every SPI frame
//   - status byte bit positions (also used by host software documentation)
//   - FSM state enumeration
// No ports (package).
// -----------------------------------------------------------------------------
package cmd_pkg;

    localparam logic [7:0] OP_CAPTURE = 8'h01;
    localparam logic [7:0] OP_DAC_WR  = 8'h02;
    localparam logic [7:0] OP_STATUS  = 8'h03;

    // Status byte layout: [7:4] VERSION, [3] reserved (0), [2:0] error flags.
    localparam int STAT_BRESP_BIT = 0;
    localparam int STAT_OP_BIT    = 1;
    localparam int STAT_SHORT_BIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CAP,
        ST_AW,
        ST_W,
        ST_B,
        ST_STAT,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/cmd_sequencer.sv
// -----------------------------------------------------------------------------
// cmd_sequencer
// Decodes command frames arriving on the SPI receive byte stream and runs them:
//   CAPTURE (0x01, len_hi, len_lo)          : forward len ADC samples to SPI send
//   DAC_WR  (0x02, addr_hi, addr_lo, n, d*) : AXI4 burst of n+1 bytes to DAC memory
//   STATUS  (0x03)                          : return {VERSION, 0, short, op, bresp}
// Owns the sticky error flags reported by STATUS.
// Ports:
//   axi_aclk / axi_aresetn      clock, async active-low reset
//   spi_recv_axis_*             command bytes in (rlast = frame end)
//   spi_send_axis_*             response bytes out
//   adc_axis_*                  ADC sample stream in (tlast unused)
//   dac_axi_aw* / w* / b*       AXI4 write channels toward DAC memory
// -----------------------------------------------------------------------------
module cmd_sequencer
    import cmd_pkg::*;
#(
    parameter int         ADDR_W           = 16,
    parameter logic [3:0] VERSION          = 4'h1,
    parameter bit         ADC_DISCARD_IDLE = 1'b1
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,

    input  logic              spi_recv_axis_rvalid,
    output logic              spi_recv_axis_rready,
    input  logic [7:0]        spi_recv_axis_rdata,
    input  logic              spi_recv_axis_rlast,

    output logic              spi_send_axis_tvalid,
    input  logic              spi_send_axis_tready,
    output logic [7:0]        spi_send_axis_tdata,
    output logic              spi_send_axis_tlast,

    input  logic              adc_axis_tvalid,
    output logic              adc_axis_tready,
    input  logic [7:0]        adc_axis_tdata,
    input  logic              adc_axis_tlast,

    output logic [ADDR_W-1:0] dac_axi_awaddr,
    output logic              dac_axi_awvalid,
    input  logic              dac_axi_awready,

    output logic [7:0]        dac_axi_wdata,
    output logic              dac_axi_wvalid,
    input  logic              dac_axi_wready,
    output logic              dac_axi_wlast,

    input  logic [1:0]        dac_axi_bresp,
    input  logic              dac_axi_bvalid,
    output logic              dac_axi_bready
);

    state_e      state_q, state_d;
    logic [23:0] hdr_q, hdr_d;          // header bytes shifted in MSB first
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic        is_dac_q, is_dac_d;
    logic [15:0] cap_cnt_q, cap_cnt_d;
    logic [7:0]  beat_q, beat_d;
    logic        pad_q, pad_d;          // frame ended early: fill W beats with zeros
    logic        rlast_seen_q, rlast_seen_d;
    logic        err_short_q, err_op_q, err_bresp_q;
    logic        en_q;                  // holds all handshake outputs low until out of reset

    logic        set_short, set_op, set_bresp, clr_flags;
    logic        w_fire, cap_last, w_last;
    logic [7:0]  status;
    state_e      after_op;

    logic        unused_adc_tlast;
    assign unused_adc_tlast = adc_axis_tlast;

    // Address field occupies header bytes 1..2; n is byte 3.
    assign dac_axi_awaddr = ADDR_W'(hdr_q[23:8]);

    // Leftover frame bytes must be consumed before the next opcode is trusted.
    assign after_op = rlast_seen_q ? ST_IDLE : ST_DRAIN;
    assign cap_last = (cap_cnt_q == hdr_q[15:0] - 16'd1);
    assign w_last   = (beat_q == hdr_q[7:0]);
    assign w_fire   = (pad_q || spi_recv_axis_rvalid) && dac_axi_wready;

    always_comb begin
        status                 = '0;
        status[7:4]            = VERSION;
        status[STAT_SHORT_BIT] = err_short_q;
        status[STAT_OP_BIT]    = err_op_q;
        status[STAT_BRESP_BIT] = err_bresp_q;
    end

    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        hdr_cnt_d    = hdr_cnt_q;
        is_dac_d     = is_dac_q;
        cap_cnt_d    = cap_cnt_q;
        beat_d       = beat_q;
        pad_d        = pad_q;
        rlast_seen_d = rlast_seen_q;
        set_short    = 1'b0;
        set_op       = 1'b0;
        set_bresp    = 1'b0;
        clr_flags    = 1'b0;

        spi_recv_axis_rready = 1'b0;
        spi_send_axis_tvalid = 1'b0;
        spi_send_axis_tdata  = 8'h00;
        spi_send_axis_tlast  = 1'b0;
        adc_axis_tready      = 1'b0;
        dac_axi_awvalid      = 1'b0;
        dac_axi_wvalid       = 1'b0;
        dac_axi_wdata        = 8'h00;
        dac_axi_wlast        = 1'b0;
        dac_axi_bready       = 1'b0;

        if (en_q) begin
            adc_axis_tready = ADC_DISCARD_IDLE;
            case (state_q)
                ST_IDLE: begin
                    spi_recv_axis_rready = 1'b1;
                    if (spi_recv_axis_rvalid) begin
                        rlast_seen_d = spi_recv_axis_rlast;
                        case (spi_recv_axis_rdata)
                            OP_CAPTURE, OP_DAC_WR: begin
                                is_dac_d  = (spi_recv_axis_rdata == OP_DAC_WR);
                                hdr_cnt_d = 2'd0;
                                if (spi_recv_axis_rlast) set_short = 1'b1;
                                else                     state_d   = ST_HDR;
                            end
                            OP_STATUS: state_d = ST_STAT;
                            default: begin
                                set_op = 1'b1;
                                if (!spi_recv_axis_rlast) state_d = ST_DRAIN;
                            end
                        endcase
                    end
                end
                ST_HDR: begin
                    spi_recv_axis_rready = 1'b1;
                    if (spi_recv_axis_rvalid) begin
                        hdr_d        = {hdr_q[15:0], spi_recv_axis_rdata};
                        hdr_cnt_d    = hdr_cnt_q + 2'd1;
                        rlast_seen_d = spi_recv_axis_rlast;
                        if (hdr_cnt_q == (is_dac_q ? 2'd2 : 2'd1)) begin
                            if (is_dac_q) begin
                                // Frame ending on n means every data beat is missing.
                                beat_d    = 8'd0;
                                pad_d     = spi_recv_axis_rlast;
                                set_short = spi_recv_axis_rlast;
                                state_d   = ST_AW;
                            end else begin
                                cap_cnt_d = 16'd0;
                                if ({hdr_q[7:0], spi_recv_axis_rdata} == 16'd0)
                                    state_d = spi_recv_axis_rlast ? ST_IDLE : ST_DRAIN;
                                else
                                    state_d = ST_CAP;
                            end
                        end else if (spi_recv_axis_rlast) begin
                            set_short = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                end
                ST_CAP: begin
                    adc_axis_tready      = spi_send_axis_tready;
                    spi_send_axis_tvalid = adc_axis_tvalid;
                    spi_send_axis_tdata  = adc_axis_tdata;
                    spi_send_axis_tlast  = cap_last;
                    if (adc_axis_tvalid && spi_send_axis_tready) begin
                        cap_cnt_d = cap_cnt_q + 16'd1;
                        if (cap_last) state_d = after_op;
                    end
                end
                ST_AW: begin
                    dac_axi_awvalid = 1'b1;
                    if (dac_axi_awready) state_d = ST_W;
                end
                ST_W: begin
                    dac_axi_wlast = w_last;
                    if (pad_q) begin
                        dac_axi_wvalid = 1'b1;
                    end else begin
                        dac_axi_wvalid       = spi_recv_axis_rvalid;
                        dac_axi_wdata        = spi_recv_axis_rdata;
                        spi_recv_axis_rready = dac_axi_wready;
                    end
                    if (w_fire) begin
                        beat_d = beat_q + 8'd1;
                        if (!pad_q) begin
                            rlast_seen_d = spi_recv_axis_rlast;
                            if (spi_recv_axis_rlast && !w_last) begin
                                pad_d     = 1'b1;
                                set_short = 1'b1;
                            end
                        end
                        if (w_last) state_d = ST_B;
                    end
                end
                ST_B: begin
                    dac_axi_bready = 1'b1;
                    if (dac_axi_bvalid) begin
                        set_bresp = (dac_axi_bresp != 2'b00);
                        state_d   = after_op;
                    end
                end
                ST_STAT: begin
                    spi_send_axis_tvalid = 1'b1;
                    spi_send_axis_tlast  = 1'b1;
                    spi_send_axis_tdata  = status;
                    if (spi_send_axis_tready) begin
                        clr_flags = 1'b1;
                        state_d   = after_op;
                    end
                end
                ST_DRAIN: begin
                    spi_recv_axis_rready = 1'b1;
                    if (spi_recv_axis_rvalid && spi_recv_axis_rlast) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q      <= ST_IDLE;
            hdr_q        <= '0;
            hdr_cnt_q    <= '0;
            is_dac_q     <= 1'b0;
            cap_cnt_q    <= '0;
            beat_q       <= '0;
            pad_q        <= 1'b0;
            rlast_seen_q <= 1'b0;
            err_short_q  <= 1'b0;
            err_op_q     <= 1'b0;
            err_bresp_q  <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            hdr_cnt_q    <= hdr_cnt_d;
            is_dac_q     <= is_dac_d;
            cap_cnt_q    <= cap_cnt_d;
            beat_q       <= beat_d;
            pad_q        <= pad_d;
            rlast_seen_q <= rlast_seen_d;
            // A flag raised in the same cycle as the STATUS clear survives.
            err_short_q  <= (err_short_q & ~clr_flags) | set_short;
            err_op_q     <= (err_op_q    & ~clr_flags) | set_op;
            err_bresp_q  <= (err_bresp_q & ~clr_flags) | set_bresp;
            en_q         <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
module tb_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       r_valid = 1'b0, r_ready, r_last = 1'b0;
    logic [7:0] r_data = 8'h00;
    logic       s_tvalid, s_tready = 1'b1, s_tlast;
    logic [7:0] s_tdata;
    logic       adc_tvalid = 1'b0, adc_tready, adc_tlast = 1'b0;
    logic [7:0] adc_tdata = 8'h00;
    logic [15:0] awaddr;
    logic       awvalid, awready = 1'b0;
    logic [7:0] wdata;
    logic       wvalid, wready = 1'b0, wlast;
    logic [1:0] bresp = 2'b00;
    logic       bvalid = 1'b0, bready;

    always #5 clk = ~clk;

    cmd_sequencer dut (
        .axi_aclk             (clk),
        .axi_aresetn          (rstn),
        .spi_recv_axis_rvalid (r_valid),
        .spi_recv_axis_rready (r_ready),
        .spi_recv_axis_rdata  (r_data),
        .spi_recv_axis_rlast  (r_last),
        .spi_send_axis_tvalid (s_tvalid),
        .spi_send_axis_tready (s_tready),
        .spi_send_axis_tdata  (s_tdata),
        .spi_send_axis_tlast  (s_tlast),
        .adc_axis_tvalid      (adc_tvalid),
        .adc_axis_tready      (adc_tready),
        .adc_axis_tdata       (adc_tdata),
        .adc_axis_tlast       (adc_tlast),
        .dac_axi_awaddr       (awaddr),
        .dac_axi_awvalid      (awvalid),
        .dac_axi_awready      (awready),
        .dac_axi_wdata        (wdata),
        .dac_axi_wvalid       (wvalid),
        .dac_axi_wready       (wready),
        .dac_axi_wlast        (wlast),
        .dac_axi_bresp        (bresp),
        .dac_axi_bvalid       (bvalid),
        .dac_axi_bready       (bready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0]  send_q[$];
    logic [8:0]  w_q[$];
    logic [15:0] aw_q[$];
    int          overlap_cnt = 0;
    int          mirror_err  = 0;
    bit          cap_window  = 1'b0;
    bit          got_b;

    // Handshake recorder: samples mid low phase, handshake completes at next posedge.
    always @(negedge clk) begin
        #2;
        if (rstn) begin
            if (s_tvalid && s_tready) send_q.push_back({s_tlast, s_tdata});
            if (wvalid && wready)     w_q.push_back({wlast, wdata});
            if (awvalid && awready)   aw_q.push_back(awaddr);
            if (awvalid && wvalid)    overlap_cnt++;
            if (cap_window && s_tvalid && (adc_tready !== s_tready)) mirror_err++;
        end
    end

    task automatic recv_byte(input logic [7:0] d, input logic last);
        int t;
        t = 0;
        r_valid = 1'b1; r_data = d; r_last = last;
        #1;
        while (!r_ready && t < 100) begin
            @(negedge clk); #1; t++;
        end
        if (!r_ready) begin
            n_checks++;
            $display("FAIL recv_timeout byte=%02h rready=%b required=1", d, r_ready);
        end
        @(posedge clk);
        @(negedge clk);
        r_valid = 1'b0; r_last = 1'b0;
    endtask

    task automatic adc_stream(input logic [7:0] start, input int cycles);
        logic [7:0] v;
        v = start;
        for (int i = 0; i < cycles; i++) begin
            adc_tvalid = 1'b1; adc_tdata = v;
            #1;
            if (adc_tready) v = v + 8'd1;
            @(negedge clk);
        end
        adc_tvalid = 1'b0;
    endtask

    task automatic tready_toggle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            s_tready = (i % 2 == 0);
            @(negedge clk);
        end
        s_tready = 1'b1;
    endtask

    task automatic axi_slave(input int aw_delay, input logic [1:0] resp);
        int t;
        got_b = 1'b0; awready = 1'b0; wready = 1'b1; bvalid = 1'b0; bresp = resp;
        t = 0;
        #1;
        while (!awvalid && t < 100) begin @(negedge clk); #1; t++; end
        if (!awvalid) begin
            n_checks++;
            $display("FAIL aw_timeout awvalid=%b required=1", awvalid);
        end
        repeat (aw_delay) @(negedge clk);
        awready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awready = 1'b0;
        t = 0;
        #1;
        while (!bready && t < 100) begin @(negedge clk); #1; t++; end
        if (!bready) begin
            n_checks++;
            $display("FAIL b_timeout bready=%b required=1", bready);
        end
        got_b = bready;
        bvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
    endtask

    task automatic do_status(input logic [7:0] expected, input string name);
        int t;
        send_q.delete();
        s_tready = 1'b1;
        recv_byte(8'h03, 1'b1);
        t = 0;
        while (send_q.size() == 0 && t < 20) begin @(negedge clk); #3; t++; end
        @(negedge clk);
        n_checks++;
        if (send_q.size() == 0)
            $display("FAIL %s no status byte, required %02h", name, expected);
        else if (send_q[0] !== {1'b1, expected})
            $display("FAIL %s got last/data=%b/%02h required 1/%02h", name, send_q[0][8], send_q[0][7:0], expected);
        else begin
            n_pass++;
            $display("status %s = %02h", name, send_q[0][7:0]);
        end
    endtask

    task automatic check_w(input string name, input logic [8:0] exp_beats[4], input int n);
        n_checks++;
        if (w_q.size() !== n) $display("FAIL %s_wcount got %0d required %0d", name, w_q.size(), n);
        else n_pass++;
        for (int i = 0; i < n && i < w_q.size(); i++) begin
            n_checks++;
            if (w_q[i] !== exp_beats[i])
                $display("FAIL %s_wbeat%0d got %03h required %03h", name, i, w_q[i], exp_beats[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        logic [39:0] outs;
        @(negedge clk); #1;
        outs = {r_ready, s_tvalid, s_tlast, s_tdata, adc_tready, awvalid, awaddr,
                wvalid, wdata, wlast, bready};
        n_checks++;
        if (outs !== 40'd0) $display("FAIL reset_outputs got %010h required 0", outs);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({r_ready, adc_tready, s_tvalid} !== 3'b110)
            $display("FAIL reset_idle got rready/adc_tready/tvalid=%b required 110", {r_ready, adc_tready, s_tvalid});
        else n_pass++;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_capture_basic();
        send_q.delete();
        s_tready = 1'b1;
        recv_byte(8'h01, 1'b0); recv_byte(8'h00, 1'b0); recv_byte(8'h05, 1'b1);
        adc_stream(8'h10, 17);
        n_checks++;
        if (send_q.size() !== 5) $display("FAIL cap5_count got %0d required 5", send_q.size());
        else n_pass++;
        for (int i = 0; i < 5 && i < send_q.size(); i++) begin
            n_checks++;
            if (send_q[i] !== {(i == 4), 8'h10 + 8'(i)})
                $display("FAIL cap5_beat%0d got %03h required %03h", i, send_q[i], {(i == 4), 8'h10 + 8'(i)});
            else n_pass++;
        end
        #1;
        n_checks++;
        if ({r_ready, s_tvalid} !== 2'b10) $display("FAIL cap5_idle got rready/tvalid=%b required 10", {r_ready, s_tvalid});
        else n_pass++;
        @(negedge clk);
        $display("capture len=5 -> %0d bytes", send_q.size());
    endtask

    task automatic test_capture_backpressure();
        send_q.delete();
        mirror_err = 0;
        recv_byte(8'h01, 1'b0); recv_byte(8'h00, 1'b0); recv_byte(8'h03, 1'b1);
        cap_window = 1'b1;
        fork
            adc_stream(8'h40, 12);
            tready_toggle(12);
        join
        cap_window = 1'b0;
        n_checks++;
        if (send_q.size() !== 3) $display("FAIL cap3_count got %0d required 3", send_q.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < send_q.size(); i++) begin
            n_checks++;
            if (send_q[i] !== {(i == 2), 8'h40 + 8'(i)})
                $display("FAIL cap3_beat%0d got %03h required %03h", i, send_q[i], {(i == 2), 8'h40 + 8'(i)});
            else n_pass++;
        end
        n_checks++;
        if (mirror_err !== 0) $display("FAIL cap3_mirror got %0d cycles adc_tready!=send_tready required 0", mirror_err);
        else n_pass++;
        $display("capture len=3 backpressured -> %0d bytes", send_q.size());
    endtask

    task automatic test_dac_write();
        logic [8:0] exp_b[4];
        exp_b = '{9'h0AA, 9'h0BB, 9'h0CC, 9'h1DD};
        w_q.delete(); aw_q.delete(); overlap_cnt = 0;
        fork
            axi_slave(4, 2'b00);
            begin
                recv_byte(8'h02, 1'b0); recv_byte(8'h01, 1'b0); recv_byte(8'h00, 1'b0); recv_byte(8'h03, 1'b0);
                recv_byte(8'hAA, 1'b0); recv_byte(8'hBB, 1'b0); recv_byte(8'hCC, 1'b0); recv_byte(8'hDD, 1'b1);
            end
        join
        n_checks++;
        if (aw_q.size() !== 1 || aw_q[0] !== 16'h0100)
            $display("FAIL dac_awaddr got n=%0d addr=%04h required 1 addr=0100", aw_q.size(), (aw_q.size() > 0) ? aw_q[0] : 16'hxxxx);
        else n_pass++;
        check_w("dac", exp_b, 4);
        n_checks++;
        if (overlap_cnt !== 0 || got_b !== 1'b1)
            $display("FAIL dac_aw_w_b overlap=%0d bready_seen=%b required 0/1", overlap_cnt, got_b);
        else n_pass++;
        $display("dac write addr=0100 beats=%0d", w_q.size());
        do_status(8'h10, "after_dac_wr");
    endtask

    task automatic test_dac_short();
        logic [8:0] exp_b[4];
        exp_b = '{9'h0AA, 9'h0BB, 9'h000, 9'h100};
        w_q.delete(); aw_q.delete();
        fork
            axi_slave(0, 2'b00);
            begin
                recv_byte(8'h02, 1'b0); recv_byte(8'h12, 1'b0); recv_byte(8'h34, 1'b0); recv_byte(8'h03, 1'b0);
                recv_byte(8'hAA, 1'b0); recv_byte(8'hBB, 1'b1);
            end
        join
        n_checks++;
        if (aw_q.size() !== 1 || aw_q[0] !== 16'h1234)
            $display("FAIL short_awaddr got n=%0d required 1 addr=1234", aw_q.size());
        else n_pass++;
        check_w("short", exp_b, 4);
        $display("dac short write beats=%0d", w_q.size());
        do_status(8'h14, "short_err");
        do_status(8'h10, "short_cleared");
    endtask

    task automatic test_bad_opcode();
        recv_byte(8'h7E, 1'b0); recv_byte(8'h11, 1'b0); recv_byte(8'h22, 1'b1);
        $display("bad opcode 7E drained");
        do_status(8'h12, "bad_op");
        do_status(8'h10, "bad_op_cleared");
    endtask

    task automatic test_bresp_error();
        logic [8:0] exp_b[4];
        exp_b = '{9'h155, 9'h000, 9'h000, 9'h000};
        w_q.delete();
        fork
            axi_slave(1, 2'b10);
            begin
                recv_byte(8'h02, 1'b0); recv_byte(8'h00, 1'b0); recv_byte(8'h40, 1'b0); recv_byte(8'h00, 1'b0);
                recv_byte(8'h55, 1'b1);
            end
        join
        check_w("bresp", exp_b, 1);
        $display("dac write with bresp=10");
        do_status(8'h11, "bresp_err");
    endtask

    task automatic test_reset_midburst();
        logic [39:0] outs;
        awready = 1'b1; wready = 1'b1;
        recv_byte(8'h02, 1'b0); recv_byte(8'h00, 1'b0); recv_byte(8'h20, 1'b0); recv_byte(8'h07, 1'b0);
        recv_byte(8'h01, 1'b0); recv_byte(8'h02, 1'b0);
        r_valid = 1'b1; r_data = 8'h03;
        #1;
        n_checks++;
        if ({wvalid, wdata} !== 9'h103) $display("FAIL midburst_w got wvalid/wdata=%03h required 103", {wvalid, wdata});
        else n_pass++;
        rstn = 1'b0;
        #1;
        outs = {r_ready, s_tvalid, s_tlast, s_tdata, adc_tready, awvalid, awaddr,
                wvalid, wdata, wlast, bready};
        n_checks++;
        if (outs !== 40'd0) $display("FAIL midburst_reset_outputs got %010h required 0", outs);
        else n_pass++;
        r_valid = 1'b0; awready = 1'b0; wready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("reset during W burst");
        do_status(8'h10, "after_reset");
    endtask

    initial begin
        test_reset();
        test_capture_basic();
        test_capture_backpressure();
        test_dac_write();
        test_dac_short();
        test_bad_opcode();
        test_bresp_error();
        test_reset_midburst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1, "timeout");
    end

endmodule
